btn_event_ctrl: RTL
===================

# btn_event_ctrl

Classifies the debounced, synchronized levels of up to `NUM_BTN` buttons into SHORT, LONG and REPEAT press events. It arbitrates the events round-robin onto one valid/ready event port. It sits between the per-button debouncers and the application FSM (stopwatch/watch mode control), and replaces ad-hoc rising-edge pulses with one sequenced command stream.

## Interface
- `NUM_BTN`, 4, number of buttons; must be ≥ 2.
- `CLK_HZ`, 100_000_000, `clk` frequency; must be an integer multiple of `TICK_HZ`.
- `TICK_HZ`, 1000, timing tick rate; one tick = 1 ms by default.
- `LONG_TICKS`, 1000, hold ticks before LONG; must be ≥ 2.
- `REPEAT_TICKS`, 200, ticks between REPEAT events; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_btn_lvl`  in  NUM_BTN  debounced levels; 1 = pressed, already synchronous to `clk`.
- `o_evt_valid`  out  1  event available.
- `i_evt_ready`  in  1  consumer accepts the event when `o_evt_valid & i_evt_ready` at a rising edge.
- `o_evt_id`  out  $clog2(NUM_BTN)  button index of the event.
- `o_evt_type`  out  2  0 = SHORT, 1 = LONG, 2 = REPEAT; 3 is never driven.
- `o_drop`  out  1  one-cycle pulse when a pending event is overwritten.

## Operation
- **Tick prescaler:** counter runs 0..CLK_HZ/TICK_HZ−1. A `tick` pulse lasts one `clk` at the terminal count, and the counter then wraps to 0. It is free-running and shared by all buttons.
- **Press detect:** a per-button previous-level register. A rise is `lvl & ~prev`.
- **Per-button FSM, states IDLE / PRESS / HOLD:**
  - IDLE: on a rise → PRESS, `hold_cnt` = 0.
  - PRESS:
    - level low → post SHORT, go to IDLE.
    - otherwise, on `tick`, `hold_cnt`++.
    - on a tick with `hold_cnt` == LONG_TICKS−1 → post LONG, go to HOLD, `rep_cnt` = 0.
    - release takes priority over a LONG posted in the same cycle.
  - HOLD:
    - level low → IDLE, no event.
    - on `tick`, `rep_cnt`++.
    - on a tick with `rep_cnt` == REPEAT_TICKS−1 → post REPEAT, `rep_cnt` = 0.
- **Counter widths:** `hold_cnt` is $clog2(LONG_TICKS) bits and `rep_cnt` is $clog2(REPEAT_TICKS+1) bits. Neither counter can overflow, because each is cleared at its terminal value.
- **Pending slot:** each button has one slot (flag + type).
  - A post into a full slot overwrites the type and pulses `o_drop`.
  - A post into a slot that is being granted in the same cycle is not a drop: the grant takes the old content and the new event stays pending.
- **Output register / arbiter:**
  - The output register loads when it is empty, or when it is being accepted this cycle.
  - It loads from the pending slots, round-robin, starting at (last granted id + 1) mod NUM_BTN.
  - Granting clears that button's slot.
  - While `o_evt_valid` = 1 and `i_evt_ready` = 0, `o_evt_id` and `o_evt_type` hold stable.

## Timing
- **Reset values:**
  - `o_evt_valid`, `o_evt_id`, `o_evt_type`, `o_drop` = 0.
  - All FSMs in IDLE; slots empty; prescaler 0.
  - Round-robin pointer set so that button 0 has top priority.
  - `prev` = all ones, so a button held through reset is ignored until it is released.
- **Latency:** a condition sampled at edge k sets the slot at edge k. `o_evt_valid` rises at edge k+1 if the output register is free.
- **Back-to-back:** with `i_evt_ready` held at 1, one event is transferred per cycle.
- **Reset mid-operation:** all state is cleared immediately, including pending and unaccepted events.

## Configuration
- **`BTN_CTRL_REPEAT_EN` defined:** HOLD emits REPEAT every REPEAT_TICKS ticks, as described above.
- **`BTN_CTRL_REPEAT_EN` undefined:**
  - HOLD only waits for release.
  - `rep_cnt` is not built; REPEAT is never produced.
  - SHORT and LONG behaviour is unchanged.

## Structure
- Package `btn_ctrl_pkg`: event-type constants `EVT_SHORT`, `EVT_LONG`, `EVT_REPEAT`; FSM state encodings.
- Sub-module `btn_press_fsm`, one instance per button. It holds the prev-level register, the FSM, both counters, and outputs a `post` strobe plus the event type.
- Prescaler, pending slots and arbiter live in the top module.

## Test plan
All scenarios use CLK_HZ = 1000, TICK_HZ = 100 (10 clk/tick), LONG_TICKS = 5, REPEAT_TICKS = 2, `i_evt_ready` = 1 unless stated.
1. Btn 1 high for 20 clk, then low → one event id = 1, type SHORT, valid one cycle after the falling sample; no LONG.
2. Btn 2 held 100 clk, REPEAT_EN defined → LONG after 5 ticks, then REPEAT every 2 ticks; on release no further event. With REPEAT_EN undefined → LONG only.
3. Btns 0 and 3 both released in the same cycle → two events on consecutive cycles, id 0 then id 3. Repeat the case after a grant to id 0 → id 3 now has priority.
4. `i_evt_ready` = 0; btn 1 gives SHORT, then a second SHORT before acceptance → output holds the first event stable. The second event waits pending; no `o_drop`.
5. `i_evt_ready` = 0; three SHORTs on btn 1 → the third press pulses `o_drop` once. After ready rises: the first event, then the last-posted event.
6. Btn 0 held across an `rst_n` pulse asserted mid-PRESS → outputs go to 0 at once and no event follows release. The next full press yields a SHORT.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared event-type codes, per-button FSM state encoding and the round-robin
// index helper used by btn_event_ctrl and btn_press_fsm.
package btn_ctrl_pkg;

  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } btn_state_e;

  // Position 'off' in a rotation of n entries that begins at 'start'.
  function automatic int rr_index(input int start, input int off, input int n);
    return (start + off) % n;
  endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button press classifier: IDLE/PRESS/HOLD with hold and repeat counters.
// REPEAT generation and rep_cnt exist only when BTN_CTRL_REPEAT_EN is defined.
module btn_press_fsm
  import btn_ctrl_pkg::*;
#(
  parameter int LONG_TICKS = 1000
`ifdef BTN_CTRL_REPEAT_EN
  , parameter int REPEAT_TICKS = 200
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       lvl,
  output logic       post,
  output logic [1:0] evt_type
);

  localparam int HOLD_W = $clog2(LONG_TICKS);

  btn_state_e        state_r, state_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic              prev_r;
  logic              rise_s;
  logic              hold_term_s;

  assign rise_s      = lvl & ~prev_r;
  assign hold_term_s = tick && (hold_cnt_r == HOLD_W'(LONG_TICKS - 1));

`ifdef BTN_CTRL_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);

  logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
  logic             rep_term_s;

  assign rep_term_s = tick && (rep_cnt_r == REP_W'(REPEAT_TICKS - 1));
`endif

  // State register, counters and previous-level tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= HOLD_W'(0);
      prev_r     <= 1'b1;  // a button held through reset must be released first
`ifdef BTN_CTRL_REPEAT_EN
      rep_cnt_r  <= REP_W'(0);
`endif
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      prev_r     <= lvl;
`ifdef BTN_CTRL_REPEAT_EN
      rep_cnt_r  <= rep_cnt_s;
`endif
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
`ifdef BTN_CTRL_REPEAT_EN
    rep_cnt_s  = rep_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s    = ST_PRESS;
          hold_cnt_s = HOLD_W'(0);
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!lvl) begin
          state_s = ST_IDLE;
        end else if (hold_term_s) begin
          state_s = ST_HOLD;
`ifdef BTN_CTRL_REPEAT_EN
          rep_cnt_s = REP_W'(0);
`endif
        end else if (tick) begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          state_s = ST_PRESS;
        end
      end
      ST_HOLD: begin
        if (!lvl) begin
          state_s = ST_IDLE;
`ifdef BTN_CTRL_REPEAT_EN
        end else if (rep_term_s) begin
          rep_cnt_s = REP_W'(0);
        end else if (tick) begin
          rep_cnt_s = rep_cnt_r + REP_W'(1);
`endif
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Event strobe: release wins over a LONG falling on the same cycle
  always_comb begin
    post     = 1'b0;
    evt_type = EVT_SHORT;
    case (state_r)
      ST_PRESS: begin
        if (!lvl) begin
          post     = 1'b1;
          evt_type = EVT_SHORT;
        end else if (hold_term_s) begin
          post     = 1'b1;
          evt_type = EVT_LONG;
        end else begin
          post     = 1'b0;
        end
      end
      ST_HOLD: begin
`ifdef BTN_CTRL_REPEAT_EN
        if (lvl && rep_term_s) begin
          post     = 1'b1;
          evt_type = EVT_REPEAT;
        end else begin
          post     = 1'b0;
        end
`else
        post = 1'b0;
`endif
      end
      default: begin
        post = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: shared tick prescaler, per-button press FSMs, pending
// slots and a round-robin valid/ready output. BTN_CTRL_REPEAT_EN enables REPEAT.
module btn_event_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         i_btn_lvl,
  output logic                       o_evt_valid,
  input  logic                       i_evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] o_evt_id,
  output logic [1:0]                 o_evt_type,
  output logic                       o_drop
);

  localparam int ID_W     = $clog2(NUM_BTN);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (NUM_BTN < 2 || LONG_TICKS < 2 || REPEAT_TICKS < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_param
    $error("btn_event_ctrl: illegal parameter combination");
  end

  logic [TICK_W-1:0]  tick_cnt_r;
  logic               tick_s;
  logic [NUM_BTN-1:0] post_s;
  logic [1:0]         post_type_s [NUM_BTN];
  logic [NUM_BTN-1:0] pend_r;
  logic [1:0]         pend_type_r [NUM_BTN];
  logic [NUM_BTN-1:0] gnt_mask_s;
  logic               gnt_vld_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic               load_s;
  logic               take_s;
  logic               drop_s;
  int                 start_s;
  int                 idx_s;
  logic               valid_r;
  logic [ID_W-1:0]    id_r;
  logic [1:0]         type_r;
  logic [ID_W-1:0]    last_r;
  logic               drop_r;

  assign tick_s = (tick_cnt_r == TICK_W'(TICK_DIV - 1));

  // Free-running tick prescaler shared by all buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= TICK_W'(0);
    end else if (tick_s) begin
      tick_cnt_r <= TICK_W'(0);
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_press_fsm #(
      .LONG_TICKS  (LONG_TICKS)
`ifdef BTN_CTRL_REPEAT_EN
      , .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick_s),
      .lvl      (i_btn_lvl[g]),
      .post     (post_s[g]),
      .evt_type (post_type_s[g])
    );
  end

  assign load_s = !valid_r || i_evt_ready;
  assign take_s = load_s && gnt_vld_s;

  // Round-robin pick: scan offsets high to low so the lowest pending offset wins
  always_comb begin
    gnt_vld_s  = 1'b0;
    gnt_id_s   = ID_W'(0);
    idx_s      = 0;
    start_s    = rr_index(int'(last_r), 1, NUM_BTN);
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      idx_s     = rr_index(start_s, i, NUM_BTN);
      gnt_vld_s = pend_r[idx_s] ? 1'b1 : gnt_vld_s;
      gnt_id_s  = pend_r[idx_s] ? ID_W'(idx_s) : gnt_id_s;
    end
    gnt_mask_s           = {NUM_BTN{1'b0}};
    gnt_mask_s[gnt_id_s] = take_s;
  end

  // A post over a full slot is a drop unless that slot is drained this cycle
  assign drop_s = |(post_s & pend_r & ~gnt_mask_s);

  // Pending slots: a post always lands, a grant empties an un-posted slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_BTN{1'b0}};
      for (int b = 0; b < NUM_BTN; b++) begin
        pend_type_r[b] <= EVT_SHORT;
      end
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        if (post_s[b]) begin
          pend_r[b]      <= 1'b1;
          pend_type_r[b] <= post_type_s[b];
        end else if (gnt_mask_s[b]) begin
          pend_r[b]      <= 1'b0;
        end
      end
    end
  end

  // Output register: reloads only when empty or being accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      id_r    <= ID_W'(0);
      type_r  <= EVT_SHORT;
      last_r  <= ID_W'(NUM_BTN - 1);
      drop_r  <= 1'b0;
    end else begin
      drop_r <= drop_s;
      if (load_s) begin
        valid_r <= gnt_vld_s;
        if (gnt_vld_s) begin
          id_r   <= gnt_id_s;
          type_r <= pend_type_r[gnt_id_s];
          last_r <= gnt_id_s;
        end
      end
    end
  end

  assign o_evt_valid = valid_r;
  assign o_evt_id    = id_r;
  assign o_evt_type  = type_r;
  assign o_drop      = drop_r;

endmodule
